mem_bit_rmw_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the single-port bit-masked SRAM stage.
- That SRAM stage performs a zero-fill write: it stores wr_data & bit_mask, so unmasked bits are cleared.
- This block turns that into a true masked write by doing a read-modify-write. Unmasked bits keep their old value.
- Upstream side uses a valid/ready request channel and a valid/ready response channel, with one transaction outstanding at a time.

---
 rtl/mem_bit_rmw_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_bit_rmw_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bit_rmw_ctrl.sv
// Read-modify-write front-end for a zero-fill, bit-masked single-port SRAM.
// A masked write is turned into a read of the old word followed by a full
// write of the merged word, so bits outside the mask keep their old value.
// One transaction is in flight at a time. Requests and responses use
// valid/ready handshakes.
module mem_bit_rmw_ctrl #(
  parameter int ADDR       = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_bit_mask,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  // One extra bit so DEPTH == 2**ADDR is representable and never flags an error.
  localparam logic [ADDR:0] DEPTH_LIM = (ADDR + 1)'(DEPTH);

  state_t                state;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  out_of_range;

  // Merge: masked bits come from the new data, the rest from the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] mask
  );
    merge_word = (old_word & ~mask) | (new_word & mask);
  endfunction

  // Range check only feeds the state register, never the SRAM pins directly.
  assign out_of_range = ({1'b0, req_addr} >= DEPTH_LIM);

  // The merged word is always written in full, so the SRAM mask stays all ones.
  assign mem_bit_mask = '1;

  // Response fields come straight from registers that only change on accept
  // or capture, so they are stable under backpressure.
  assign rsp_rdata = data_q;
  assign rsp_err   = err_q;

  // Transaction FSM; all handshake and SRAM outputs are registered here.
  // mem_addr doubles as the latched request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            wdata_q   <= req_wdata;
            mask_q    <= req_mask;
            mem_addr  <= req_addr;
            req_ready <= 1'b0;
            if (out_of_range) begin
              // Answer immediately with an error and no SRAM access.
              err_q     <= 1'b1;
              data_q    <= '0;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else begin
              err_q  <= 1'b0;
              mem_en <= 1'b1;
              mem_wr <= 1'b0;
              state  <= RD;
            end
          end
        end

        RD: begin
          // Read strobe lasts exactly one cycle; data returns in CAP.
          mem_en <= 1'b0;
          state  <= CAP;
        end

        CAP: begin
          data_q <= mem_r_data;
          if (wr_q && (mask_q != '0)) begin
            mem_en      <= 1'b1;
            mem_wr      <= 1'b1;
            mem_wr_data <= merge_word(mem_r_data, wdata_q, mask_q);
            state       <= WR;
          end else begin
            // Reads and empty-mask writes need no write strobe.
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        WR: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end

        RSP: begin
          // Returning through IDLE keeps a consumed response from
          // overlapping the next accept.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bit_rmw_ctrl.sv
// Directed bench for mem_bit_rmw_ctrl with a behavioural zero-fill masked SRAM.
module tb_mem_bit_rmw_ctrl;

  localparam int ADDR  = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [ADDR-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_mask;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en, mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_bit_mask, mem_r_data;

  int n_chk  = 0;
  int n_fail = 0;

  // SRAM model state and strobe bookkeeping
  logic [DW-1:0]   sram [0:255];
  logic            pre_we = 1'b0;
  logic [ADDR-1:0] pre_a = '0;
  logic [DW-1:0]   pre_d = '0;
  int              en_cnt = 0;
  int              wr_cnt = 0;
  logic [DW-1:0]   last_wr_data = '0;
  logic [ADDR-1:0] last_wr_addr = '0;

  mem_bit_rmw_ctrl #(.ADDR(ADDR), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_bit_mask(mem_bit_mask),
    .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // Zero-fill masked SRAM: stores wr_data & bit_mask, read data one cycle later.
  always @(posedge clk) begin
    if (pre_we) begin
      sram[pre_a] <= pre_d;
    end else if (mem_en) begin
      if (mem_wr) sram[mem_addr] <= mem_wr_data & mem_bit_mask;
      mem_r_data <= sram[mem_addr];
    end
  end

  // Strobe counters
  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_data <= mem_wr_data;
      last_wr_addr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic send(input logic wr, input logic [ADDR-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] m);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; req_mask = m;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  // lat = clock edges from accept to the edge that raises rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic txn(input logic wr, input logic [ADDR-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] m,
                     output logic [DW-1:0] rd, output logic er,
                     output int lat, output int ens, output int wrs);
    int e0, w0;
    e0 = en_cnt; w0 = wr_cnt;
    send(wr, a, wd, m);
    wait_rsp(lat);
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); @(negedge clk);
    ens = en_cnt - e0; wrs = wr_cnt - w0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat, ens, wrs, w0;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    @(negedge clk);
    preload(8'h05, 32'hDEADBEEF);
    preload(8'h10, 32'h12345678);
    preload(8'h20, 32'hCAFEF00D);
    preload(8'h30, 32'hA5A5A5A5);
    preload(8'h40, 32'h11111111);
    preload(8'd199, 32'h0BADC0DE);

    // Reset values
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_en",    {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr",  {24'd0, mem_addr}, 32'h0);
    chk("rst_wr_data",   mem_wr_data, 32'h0);
    chk("rst_bit_mask",  mem_bit_mask, 32'hFFFFFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Read of addr 0x05: RD cycle strobes, CAP captures, then RSP
    send(1'b0, 8'h05, 32'h0, 32'h0);
    chk("rd_en_rd",     {31'd0, mem_en}, 32'd1);
    chk("rd_wr_rd",     {31'd0, mem_wr}, 32'd0);
    chk("rd_addr_rd",   {24'd0, mem_addr}, 32'h05);
    chk("rd_rsp_rd",    {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_en_cap",    {31'd0, mem_en}, 32'd0);
    chk("rd_rsp_cap",   {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rdata",     rsp_rdata, 32'hDEADBEEF);
    chk("rd_err",       {31'd0, rsp_err}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rd_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rd_done_ready", {31'd0, req_ready}, 32'd1);

    // Masked write: only byte 1 updated
    txn(1'b1, 8'h10, 32'hFFFFFFFF, 32'h0000FF00, rd, er, lat, ens, wrs);
    chk("mw_lat",     lat, 32'd3);
    chk("mw_rdata",   rd, 32'h12345678);
    chk("mw_err",     {31'd0, er}, 32'd0);
    chk("mw_wrs",     wrs, 32'd1);
    chk("mw_ens",     ens, 32'd2);
    chk("mw_wr_data", last_wr_data, 32'h1234FF78);
    chk("mw_wr_addr", {24'd0, last_wr_addr}, 32'h10);
    chk("mw_sram",    sram[8'h10], 32'h1234FF78);
    txn(1'b0, 8'h10, 32'h0, 32'h0, rd, er, lat, ens, wrs);
    chk("mw_readback", rd, 32'h1234FF78);
    chk("rd_lat",      lat, 32'd2);

    // Zero-mask write: no write strobe, old word returned, memory unchanged
    txn(1'b1, 8'h20, 32'h12345678, 32'h0, rd, er, lat, ens, wrs);
    chk("zm_wrs",   wrs, 32'd0);
    chk("zm_ens",   ens, 32'd1);
    chk("zm_rdata", rd, 32'hCAFEF00D);
    chk("zm_sram",  sram[8'h20], 32'hCAFEF00D);

    // Out of range at DEPTH, write out of range, and the last legal word
    txn(1'b0, 8'd200, 32'h0, 32'h0, rd, er, lat, ens, wrs);
    chk("oor_lat",   lat, 32'd0);
    chk("oor_err",   {31'd0, er}, 32'd1);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_ens",   ens, 32'd0);
    txn(1'b1, 8'd255, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, er, lat, ens, wrs);
    chk("oorw_err",  {31'd0, er}, 32'd1);
    chk("oorw_ens",  ens, 32'd0);
    txn(1'b0, 8'd199, 32'h0, 32'h0, rd, er, lat, ens, wrs);
    chk("last_err",   {31'd0, er}, 32'd0);
    chk("last_rdata", rd, 32'h0BADC0DE);
    chk("last_ens",   ens, 32'd1);

    // Backpressure: response held 5 cycles with a request waiting
    rsp_ready = 1'b0;
    send(1'b0, 8'h30, 32'h0, 32'h0);
    wait_rsp(lat);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h05; req_wdata = '0; req_mask = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hA5A5A5A5);
      chk("bp_err",   {31'd0, rsp_err}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_en",    {31'd0, mem_en}, 32'd0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_en",   {31'd0, mem_en}, 32'd1);
    chk("bp_next_addr", {24'd0, mem_addr}, 32'h05);
    wait_rsp(lat);
    chk("bp_next_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);

    // Reset asserted during CAP of a masked write
    w0 = wr_cnt;
    send(1'b1, 8'h40, 32'h0, 32'hFFFF0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_mem_en",    {31'd0, mem_en}, 32'd0);
    chk("mr_mem_wr",    {31'd0, mem_wr}, 32'd0);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_mem_addr",  {24'd0, mem_addr}, 32'h0);
    chk("mr_wr_data",   mem_wr_data, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_no_write", wr_cnt - w0, 32'd0);
    chk("mr_sram",     sram[8'h40], 32'h11111111);
    txn(1'b0, 8'h40, 32'h0, 32'h0, rd, er, lat, ens, wrs);
    chk("mr_readback", rd, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
